// File: rtl/spi_pkg.sv
// Shared types and frame constants for the SPI frame target.
package spi_pkg;
    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} spi_state_t;
    localparam int CMD_BITS   = 8;
    localparam int FRAME_BITS = 40;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an async input with rise/fall pulses in the clk domain.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    assign rise = sync[STAGES-1] & ~prev;
    assign fall = ~sync[STAGES-1] & prev;
endmodule

// File: rtl/spi_frame_slave.sv
// SPI mode-0 target: oversampled 40-bit {rw, addr, data} frame parser with register-side strobes.
module spi_frame_slave import spi_pkg::*; #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              addr_dv,
    output logic              rw_out,
    output logic              rxdv,
    output logic [DATA_W-1:0] rx_d,
    input  logic [DATA_W-1:0] tx_d,
    input  logic              tx_en,
    output logic              frame_abort
);
    spi_state_t             state;
    logic [5:0]             bit_cnt;
    logic [DATA_W-1:0]      shift_reg;
    logic [DATA_W-1:0]      tx_shift;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic                   cmd_done, load_tx, wr_done;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .reset_n(reset_n), .d(sclk), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
        .clk(clk), .reset_n(reset_n), .d(cs_n), .rise(cs_rise), .fall(cs_fall));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) mosi_sync <= '0;
        else          mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            tx_shift    <= '0;
            reg_addr    <= '0;
            addr_dv     <= 1'b0;
            rw_out      <= 1'b0;
            rxdv        <= 1'b0;
            rx_d        <= '0;
            frame_abort <= 1'b0;
            cmd_done    <= 1'b0;
            load_tx     <= 1'b0;
            wr_done     <= 1'b0;
        end else begin
            rxdv        <= 1'b0;
            frame_abort <= 1'b0;
            cmd_done    <= 1'b0;
            load_tx     <= 1'b0;
            wr_done     <= 1'b0;
            if (cmd_done && state == DATA) begin
                reg_addr <= shift_reg[ADDR_W-1:0];
                rw_out   <= shift_reg[ADDR_W];
                addr_dv  <= 1'b1;
                load_tx  <= 1'b1;
            end
            if (load_tx) tx_shift <= tx_en ? tx_d : '0;
            if (wr_done) begin
                rx_d <= shift_reg;
                rxdv <= 1'b1;
            end
            if (cs_rise) begin
                state   <= IDLE;
                addr_dv <= 1'b0;
                rw_out  <= 1'b0;
                if (state == CMD || state == DATA) frame_abort <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (cs_fall) begin
                        state    <= CMD;
                        bit_cnt  <= '0;
                        tx_shift <= '0;
                    end
                    CMD: if (sclk_rise) begin
                        shift_reg <= {shift_reg[DATA_W-2:0], mosi_sync[SYNC_STAGES-1]};
                        bit_cnt   <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'(CMD_BITS - 1)) begin
                            state    <= DATA;
                            cmd_done <= 1'b1;
                        end
                    end
                    DATA: if (sclk_rise) begin
                        shift_reg <= {shift_reg[DATA_W-2:0], mosi_sync[SYNC_STAGES-1]};
                        bit_cnt   <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'(FRAME_BITS - 1)) begin
                            state   <= DONE;
                            wr_done <= ~rw_out;
                        end
                    // The fall right after the command byte must not shift, or bit 31 is lost.
                    end else if (sclk_fall && bit_cnt > 6'(CMD_BITS)) begin
                        tx_shift <= tx_shift << 1;
                    end
                    DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // cs_rise gating keeps miso low on the very cycle the synced select goes high.
    assign miso = (state == DATA) & ~cs_rise & tx_shift[DATA_W-1];
endmodule

// File: tb/tb_spi_frame_slave.sv
// Randomised and directed frame bench for spi_frame_slave with a frame-level reference model.
module tb_spi_frame_slave;
    logic        clk = 1'b0;
    logic        reset_n, sclk, cs_n, mosi, miso;
    logic [6:0]  reg_addr;
    logic        addr_dv, rw_out, rxdv, tx_en, frame_abort;
    logic [31:0] rx_d, tx_d;

    int n_chk = 0, n_err = 0;
    int rxdv_pulses = 0, rxdv_hi = 0, abort_pulses = 0;
    logic rxdv_prev = 1'b0, abort_prev = 1'b0;
    logic [31:0] exp_rx = '0;
    logic [6:0]  exp_addr = '0;

    spi_frame_slave dut (
        .clk(clk), .reset_n(reset_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .reg_addr(reg_addr), .addr_dv(addr_dv), .rw_out(rw_out), .rxdv(rxdv), .rx_d(rx_d),
        .tx_d(tx_d), .tx_en(tx_en), .frame_abort(frame_abort));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rxdv) begin
            rxdv_hi++;
            if (!rxdv_prev) rxdv_pulses++;
        end
        if (frame_abort && !abort_prev) abort_pulses++;
        rxdv_prev  = rxdv;
        abort_prev = frame_abort;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Host side of one frame: nbits clocked out MSB first, optional deselect plus frame-level checks.
    task automatic xfer(input string tag, input logic [7:0] cmd, input logic [31:0] data,
                        input int nbits, input bit raise_cs, input bit ten, input logic [31:0] td);
        logic [39:0] word;
        logic [31:0] rd;
        int p0, h0, a0;
        bit full, wr;
        word  = {cmd, data};
        rd    = '0;
        tx_en = ten;
        tx_d  = td;
        p0 = rxdv_pulses; h0 = rxdv_hi; a0 = abort_pulses;
        cs_n = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            mosi = word[39-i];
            tick(4);
            sclk = 1'b1;
            if (i >= 8) rd[39-i] = miso;
            tick(4);
            sclk = 1'b0;
        end
        tick(4);
        if (!raise_cs) return;
        full = (nbits == 40);
        wr   = full && !cmd[7];
        chk({tag, ".addr_dv"}, 64'(addr_dv), 64'(nbits >= 8));
        if (nbits >= 8) begin
            chk({tag, ".reg_addr"}, 64'(reg_addr), 64'(cmd[6:0]));
            chk({tag, ".rw_out"}, 64'(rw_out), 64'(cmd[7]));
            exp_addr = cmd[6:0];
        end
        if (full) chk({tag, ".miso_done"}, 64'(miso), 64'd0);
        cs_n = 1'b1;
        tick(16);
        if (wr) exp_rx = data;
        chk({tag, ".addr_dv_off"}, 64'({addr_dv, rw_out}), 64'd0);
        chk({tag, ".reg_addr_hold"}, 64'(reg_addr), 64'(exp_addr));
        chk({tag, ".miso_idle"}, 64'(miso), 64'd0);
        chk({tag, ".abort"}, 64'(abort_pulses - a0), 64'(!full));
        chk({tag, ".rxdv_cnt"}, 64'(rxdv_pulses - p0), 64'(wr));
        chk({tag, ".rxdv_len"}, 64'(rxdv_hi - h0), 64'(wr));
        chk({tag, ".rx_d"}, 64'(rx_d), 64'(exp_rx));
        if (full && cmd[7]) chk({tag, ".rdata"}, 64'(rd), 64'(ten ? td : 32'd0));
    endtask

    initial begin
        int nb, a0, p0;
        reset_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_en = 1'b0; tx_d = '0;
        tick(3);
        chk("reset", {miso, reg_addr, addr_dv, rw_out, rxdv, rx_d, frame_abort}, 64'd0);
        reset_n = 1'b1;
        tick(5);

        xfer("wr06", 8'h06, 32'hDEADBEEF, 40, 1, 0, 32'h0);
        xfer("rd86", 8'h86, 32'h0, 40, 1, 1, 32'h12345678);
        xfer("rd85", 8'h85, 32'h0, 40, 1, 0, 32'hFFFFFFFF);
        xfer("abort", 8'h06, 32'h0BADF00D, 28, 1, 0, 32'h0);
        xfer("b2b1", 8'h06, 32'h1, 40, 1, 0, 32'h0);
        xfer("b2b2", 8'h06, 32'h2, 40, 1, 0, 32'h0);

        // Reset mid-DATA with cs_n still low; stray sclk edges afterwards must be ignored.
        a0 = abort_pulses; p0 = rxdv_pulses;
        xfer("mid", 8'h06, 32'hFFFF0000, 20, 0, 0, 32'h0);
        reset_n = 1'b0;
        tick(2);
        chk("mid_reset", {miso, reg_addr, addr_dv, rw_out, rxdv, rx_d, frame_abort}, 64'd0);
        exp_rx = '0; exp_addr = '0;
        reset_n = 1'b1;
        tick(4);
        repeat (4) begin
            sclk = 1'b1; tick(4); sclk = 1'b0; tick(4);
        end
        cs_n = 1'b1;
        tick(16);
        chk("post_reset_quiet", 64'({addr_dv, 16'(abort_pulses - a0), 16'(rxdv_pulses - p0)}), 64'd0);
        xfer("wrA5", 8'h06, 32'hA5A5A5A5, 40, 1, 0, 32'h0);

        for (int k = 0; k < 14; k++) begin
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 39)) : 40;
            xfer($sformatf("rnd%0d", k), 8'($urandom), $urandom, nb, 1, 1'($urandom), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
